pc_queue_reader: RTL and testbench

//  Read-side controller and storage for the program-counter queue. The decoder's NOPDF pushes the

---
 rtl/pcq_pkg.sv | 25 ++
 rtl/pc_queue_reader_if.sv | 45 ++++
 rtl/pcq_storage.sv | 55 +++++
 rtl/pc_queue_reader.sv | 107 ++++++++++
 tb/tb_pc_queue_reader.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/pcq_pkg.sv
// ============================================================================
// pcq_pkg : shared defaults, pointer/count typedefs and width helper for the
//           program-counter queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pcq_pkg;

    localparam int PCQ_DATA_W = 8;
    localparam int PCQ_DEPTH  = 8;

    function automatic int pcq_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PCQ_ADDR_W = pcq_addr_w(PCQ_DEPTH);

    typedef logic [PCQ_ADDR_W-1:0] pcq_ptr_t;
    typedef logic [PCQ_ADDR_W:0]   pcq_cnt_t;
    typedef logic [PCQ_DATA_W-1:0] pcq_data_t;

endpackage

`default_nettype wire

// File: rtl/pc_queue_reader_if.sv
// ============================================================================
// pc_queue_reader_if : push/pop strobes and status of the pc queue.
//                      PCQ_ERROR_FLAGS_EN adds sticky overflow/underflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pc_queue_reader_if
    import pcq_pkg::*;
#(
    parameter int DATA_W = PCQ_DATA_W,
    parameter int DEPTH  = PCQ_DEPTH
);
    localparam int ADDR_W = pcq_addr_w(DEPTH);

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
`ifdef PCQ_ERROR_FLAGS_EN
    logic              overflow;
    logic              underflow;

    modport master (output push, push_data, pop,
                    input  pop_data, pop_valid, head, tail, count, empty, full,
                           overflow, underflow);
    modport slave  (input  push, push_data, pop,
                    output pop_data, pop_valid, head, tail, count, empty, full,
                           overflow, underflow);
`else
    modport master (output push, push_data, pop,
                    input  pop_data, pop_valid, head, tail, count, empty, full);
    modport slave  (input  push, push_data, pop,
                    output pop_data, pop_valid, head, tail, count, empty, full);
`endif

endinterface

`default_nettype wire

// File: rtl/pcq_storage.sv
// ============================================================================
// pcq_storage : DEPTH x DATA_W register array, one write port and a
//               registered read port, both on posedge clk.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pcq_storage
    import pcq_pkg::*;
#(
    parameter int DATA_W = PCQ_DATA_W,
    parameter int DEPTH  = PCQ_DEPTH
)(
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        wr_en,
    input  wire logic [pcq_addr_w(DEPTH)-1:0] wr_addr,
    input  wire logic [DATA_W-1:0]           wr_data,
    input  wire logic                        rd_en,
    input  wire logic [pcq_addr_w(DEPTH)-1:0] rd_addr,
    output logic      [DATA_W-1:0]           rd_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Read sees pre-edge contents, so a same-cycle write to the head slot
    // (full queue, push+pop) still returns the old entry.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Contents deliberately survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/pc_queue_reader.sv
// ============================================================================
// pc_queue_reader : pc queue control (pointers, occupancy, accept logic).
//                   Optional sticky error flags under PCQ_ERROR_FLAGS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_queue_reader
    import pcq_pkg::*;
#(
    parameter int DATA_W = PCQ_DATA_W,
    parameter int DEPTH  = PCQ_DEPTH
)(
    input  wire logic         clk,
    input  wire logic         sync_reset,
    pc_queue_reader_if.slave  bus
);
    localparam int                ADDR_W   = pcq_addr_w(DEPTH);
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_valid_q, pop_valid_d;
    logic              push_acc;
    logic              pop_acc;
    logic [DATA_W-1:0] rd_data;

    // Pop looks only at pre-edge occupancy; a full queue can always take a
    // push when a pop frees the head slot in the same cycle.
    always_comb begin
        pop_acc     = bus.pop && (count_q != '0);
        push_acc    = bus.push && ((count_q != FULL_CNT) || pop_acc);
        head_d      = pop_acc  ? head_q + 1'b1 : head_q;
        tail_d      = push_acc ? tail_q + 1'b1 : tail_q;
        pop_valid_d = pop_acc;
        count_d     = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    pcq_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk     (clk),
        .rst     (sync_reset),
        .wr_en   (push_acc),
        .wr_addr (tail_q),
        .wr_data (bus.push_data),
        .rd_en   (pop_acc),
        .rd_addr (head_q),
        .rd_data (rd_data)
    );

`ifdef PCQ_ERROR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (bus.push & ~push_acc);
        underflow_d = underflow_q | (bus.pop  & ~pop_acc);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

    assign bus.pop_data  = rd_data;
    assign bus.pop_valid = pop_valid_q;
    assign bus.head      = head_q;
    assign bus.tail      = tail_q;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == FULL_CNT);

endmodule

`default_nettype wire

// File: tb/tb_pc_queue_reader.sv
// ============================================================================
// tb_pc_queue_reader : directed stimulus against a queue model; expected pop
//                      data flows through a scoreboard queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_queue_reader;
    import pcq_pkg::*;

    logic clk;
    logic sync_reset;

    int errors = 0;
    int checks = 0;

    pc_queue_reader_if #(.DATA_W(8), .DEPTH(8)) bus ();

    pc_queue_reader #(.DATA_W(8), .DEPTH(8)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] model[$];
    logic [7:0] sb[$];
    logic [7:0] exp_pop_data;
    pcq_ptr_t   m_head;
    pcq_ptr_t   m_tail;
    logic       m_ovf;
    logic       m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input logic exp_valid);
        chk("pop_valid", 32'(bus.pop_valid), 32'(exp_valid));
        chk("pop_data",  32'(bus.pop_data),  32'(exp_pop_data));
        chk("count",     32'(bus.count),     32'(model.size()));
        chk("empty",     32'(bus.empty),     32'(model.size() == 0));
        chk("full",      32'(bus.full),      32'(model.size() == 8));
        chk("head",      32'(bus.head),      32'(m_head));
        chk("tail",      32'(bus.tail),      32'(m_tail));
`ifdef PCQ_ERROR_FLAGS_EN
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
`endif
    endtask

    task automatic step(input logic p, input logic [7:0] d, input logic q);
        logic pop_ok;
        logic push_ok;
        @(negedge clk);
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = q;
        pop_ok  = q && (model.size() != 0);
        push_ok = p && ((model.size() < 8) || pop_ok);
        if (pop_ok) begin
            sb.push_back(model.pop_front());
            m_head = m_head + 1'b1;
        end
        if (push_ok) begin
            model.push_back(d);
            m_tail = m_tail + 1'b1;
        end
        if (p && !push_ok) m_ovf = 1'b1;
        if (q && !pop_ok)  m_unf = 1'b1;
        @(posedge clk);
        #1;
        if (pop_ok) exp_pop_data = sb.pop_front();
        check_status(pop_ok);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sync_reset = 1'b1;
        bus.push   = 1'b0;
        bus.pop    = 1'b0;
        @(posedge clk);
        #1;
        model.delete();
        sb.delete();
        exp_pop_data = '0;
        m_head = '0;
        m_tail = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        check_status(1'b0);
        @(negedge clk);
        sync_reset = 1'b0;
    endtask

    initial begin
        sync_reset    = 1'b1;
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.pop       = 1'b0;
        exp_pop_data  = '0;
        m_head = '0;
        m_tail = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset, then idle
        do_reset();
        step(1'b0, 8'h00, 1'b0);

        // Three pushes then three pops
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Fill, overflow push, drain with wrap
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b1, 8'h28, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        chk("head_wrapped", 32'(bus.head), 32'd0);
        chk("tail_wrapped", 32'(bus.tail), 32'd0);

        // Full queue, simultaneous push+pop
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b1, 8'h30, 1'b1);
        chk("full_pp_data", 32'(bus.pop_data), 32'h20);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        chk("last_entry", 32'(bus.pop_data), 32'h30);

        // Empty queue, simultaneous push+pop: pop rejected
        step(1'b1, 8'h40, 1'b1);
        chk("empty_pp_count", 32'(bus.count), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("empty_pp_data", 32'(bus.pop_data), 32'h40);
        step(1'b0, 8'h00, 1'b0);

        // Reset discards queued entries
        step(1'b1, 8'h51, 1'b0);
        step(1'b1, 8'h52, 1'b0);
        step(1'b1, 8'h53, 1'b0);
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
